// File: rtl/booth_mac_seq.sv
// Sequential radix-2 Booth multiply-accumulate: one add/sub-and-shift step per clock, product summed into a guard-bit accumulator.
// Optional macro BOOTH_MAC_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module booth_mac_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic                    acc_clear_in,
  input  logic [DATA_WIDTH-1:0]   multiplicando_in,
  input  logic [DATA_WIDTH-1:0]   multiplicador_in,
  output logic                    ready_out,
  output logic                    busy_out,
  output logic                    valid_out,
  output logic [2*DATA_WIDTH-1:0] producto_out,
  output logic [ACC_WIDTH-1:0]    resultado_out,
  output logic                    ovf_out
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH-1);

  typedef enum logic [1:0] {IDLE, CALC, ACCUM} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   m_reg;
  logic [DATA_WIDTH:0]     a_reg;
  logic [DATA_WIDTH-1:0]   q_reg;
  logic                    q_m1;
  logic [CW-1:0]           cnt;
  logic                    clear_pending;

  logic [DATA_WIDTH:0]     m_ext, a_sum;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    prod_ext, acc_sum, acc_nxt;
  logic                    acc_ovf;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = CALC;
      CALC:    if (cnt == LAST_STEP) state_nxt = ACCUM;
      ACCUM:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready_out = (state == IDLE);
  assign busy_out  = ~ready_out;

  // One Booth step: the extra A bit keeps (-2^(N-1))^2 exact.
  always_comb begin
    m_ext = (DATA_WIDTH+1)'($signed(m_reg));
    a_sum = a_reg;
    case ({q_reg[0], q_m1})
      2'b01:   a_sum = a_reg + m_ext;
      2'b10:   a_sum = a_reg - m_ext;
      default: a_sum = a_reg;
    endcase
  end

  assign prod = {a_reg[DATA_WIDTH-1:0], q_reg};

  always_comb begin
    prod_ext = ACC_WIDTH'($signed(prod));
    acc_sum  = resultado_out + prod_ext;
    acc_ovf  = !clear_pending
             && (resultado_out[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1])
             && (acc_sum[ACC_WIDTH-1] != prod_ext[ACC_WIDTH-1]);
    acc_nxt  = clear_pending ? prod_ext : acc_sum;
`ifdef BOOTH_MAC_SAT_EN
    if (acc_ovf)
      acc_nxt = prod_ext[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    // Wrapping is the natural modulo-2^ACC_WIDTH result of the adder.
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_reg         <= '0;
      a_reg         <= '0;
      q_reg         <= '0;
      q_m1          <= 1'b0;
      cnt           <= '0;
      clear_pending <= 1'b0;
      valid_out     <= 1'b0;
      producto_out  <= '0;
      resultado_out <= '0;
      ovf_out       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            m_reg         <= multiplicando_in;
            a_reg         <= '0;
            q_reg         <= multiplicador_in;
            q_m1          <= 1'b0;
            cnt           <= '0;
            clear_pending <= acc_clear_in;
            if (acc_clear_in) ovf_out <= 1'b0;
          end else if (acc_clear_in) begin
            resultado_out <= '0;
            ovf_out       <= 1'b0;
          end
        end
        CALC: begin
          a_reg <= {a_sum[DATA_WIDTH], a_sum[DATA_WIDTH:1]};
          q_reg <= {a_sum[0], q_reg[DATA_WIDTH-1:1]};
          q_m1  <= q_reg[0];
          cnt   <= cnt + 1'b1;
        end
        ACCUM: begin
          producto_out  <= prod;
          resultado_out <= acc_nxt;
          ovf_out       <= ovf_out | acc_ovf;
          valid_out     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_seq.sv
// Directed bench for booth_mac_seq: two instances (ACC 20 and ACC 16) share one stimulus stream.
module tb_booth_mac_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start, acc_clear;
  logic [7:0] mcand, mplier;

  logic ready, busy, valid, ovf;
  logic signed [15:0] prod;
  logic signed [19:0] res;

  logic ready16, busy16, valid16, ovf16;
  logic signed [15:0] prod16;
  logic signed [15:0] res16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mac_seq #(.DATA_WIDTH(8), .ACC_WIDTH(20)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .acc_clear_in(acc_clear),
    .multiplicando_in(mcand), .multiplicador_in(mplier),
    .ready_out(ready), .busy_out(busy), .valid_out(valid),
    .producto_out(prod), .resultado_out(res), .ovf_out(ovf)
  );

  booth_mac_seq #(.DATA_WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .acc_clear_in(acc_clear),
    .multiplicando_in(mcand), .multiplicador_in(mplier),
    .ready_out(ready16), .busy_out(busy16), .valid_out(valid16),
    .producto_out(prod16), .resultado_out(res16), .ovf_out(ovf16)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns edges from acceptance to valid, or -1 on timeout.
  task automatic do_op(input int a, input int b, input logic clr, output int lat);
    int n;
    mcand = 8'(a);
    mplier = 8'(b);
    acc_clear = clr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc_clear = 1'b0;
    n = 0;
    while (!valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    lat = valid ? n : -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int vcount;
    logic signed [63:0] exp_wrap;
    rst_n = 1'b0;
    start = 1'b0;
    acc_clear = 1'b0;
    mcand = '0;
    mplier = '0;

    #2;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_prod", prod, 0);
    check("rst_res", res, 0);
    check("rst_ovf", ovf, 0);

    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic multiply
    do_op(5, -3, 1'b1, lat);
    check("t1_latency", lat, 9);
    check("t1_prod", prod, -15);
    check("t1_res", res, -15);
    check("t1_ovf", ovf, 0);
    check("t1_ready_in_valid", ready, 1);
    @(posedge clk); #1;
    check("t1_valid_pulse", valid, 0);

    // Most-negative operands
    do_op(-128, -128, 1'b1, lat);
    check("t2_prod_minsq", prod, 16384);
    check("t2_res_minsq", res, 16384);
    do_op(127, -128, 1'b0, lat);
    check("t2_prod_mix", prod, -16256);
    check("t2_res_mix", res, 128);

    // Back-to-back accumulate, second start issued in the valid cycle
    do_op(7, 6, 1'b1, lat);
    check("t3_res_first", res, 42);
    do_op(10, -2, 1'b0, lat);
    check("t3_b2b_latency", lat, 9);
    check("t3_prod_second", prod, -20);
    check("t3_res_second", res, 22);

    // Busy protection: new requests during CALC are ignored
    mcand = 8'(3);
    mplier = 8'(4);
    acc_clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc_clear = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("t4_busy_during_calc", busy, 1);
      mcand = 8'(9);
      mplier = 8'(9);
      acc_clear = 1'b1;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    acc_clear = 1'b0;
    lat = 0;
    while (!valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t4_valid_seen", valid, 1);
    check("t4_prod", prod, 12);
    check("t4_res", res, 12);

    // Standalone clear in IDLE
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    check("t5_clear_res", res, 0);
    check("t5_clear_ovf", ovf, 0);
    check("t5_clear_ready", ready, 1);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (valid) vcount++;
      @(posedge clk); #1;
    end
    check("t5_no_valid", vcount, 0);

    // Overflow on the 16-bit accumulator
    do_op(127, 127, 1'b1, lat);
    check("t6_res16_first", res16, 16129);
    do_op(127, 127, 1'b0, lat);
    check("t6_res16_second", res16, 32258);
    check("t6_ovf16_second", ovf16, 0);
    do_op(127, 127, 1'b0, lat);
`ifdef BOOTH_MAC_SAT_EN
    exp_wrap = 32767;
`else
    exp_wrap = -17149;
`endif
    check("t6_res16_third", res16, exp_wrap);
    check("t6_ovf16_third", ovf16, 1);
    check("t6_res20_third", res, 48387);
    check("t6_ovf20_third", ovf, 0);

    // Standalone clear drops sticky overflow
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    check("t7_ovf16_cleared", ovf16, 0);
    check("t7_res16_cleared", res16, 0);

    // Reset in the middle of CALC
    do_op(9, 9, 1'b1, lat);
    check("t8_pre_res", res, 81);
    mcand = 8'(5);
    mplier = 8'(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("t8_rst_ready", ready, 1);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_valid", valid, 0);
    check("t8_rst_prod", prod, 0);
    check("t8_rst_res", res, 0);
    check("t8_rst_ovf", ovf, 0);
    #2 rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    check("t8_no_valid_after", vcount, 0);
    check("t8_ready_after", ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mac_seq.md
# booth_mac_seq

Sequential, parametrised radix-2 Booth multiply-accumulate unit. It performs one Booth add/sub-and-shift step per clock, so one N×N signed multiply takes N cycles of a single adder rather than N cascaded stages. The signed product is added into a guard-bit accumulator. The block sits between the operand source and the MAC result consumer, with a start/ready request handshake and a one-cycle valid pulse on completion.

## Interface
- DATA_WIDTH, 8: operand width N, signed; legal range ≥ 2.
- ACC_WIDTH, 2*DATA_WIDTH+4: accumulator width, signed; must be ≥ 2*DATA_WIDTH.
- clk_in  input  1: single clock, rising edge.
- rst_n_in  input  1: reset, asynchronous, active-low.
- start_in  input  1: operation request; accepted only when ready_out=1.
- acc_clear_in  input  1: with start_in, the product loads the accumulator instead of adding to it. Alone in IDLE, it clears the accumulator.
- multiplicando_in  input  DATA_WIDTH: signed multiplicand, sampled at acceptance.
- multiplicador_in  input  DATA_WIDTH: signed multiplier, sampled at acceptance.
- ready_out  output  1: high only in IDLE.
- busy_out  output  1: inverse of ready_out.
- valid_out  output  1: one-cycle pulse when producto_out and resultado_out are updated.
- producto_out  output  2*DATA_WIDTH: last signed product, held until the next completion.
- resultado_out  output  ACC_WIDTH: accumulator value.
- ovf_out  output  1: sticky signed accumulation overflow; cleared by any accepted acc_clear_in.

## Operation
- The FSM has three states: IDLE, CALC and ACCUM.
- IDLE → CALC on the edge where start_in=1. On that edge the block:
  - latches M=multiplicando_in;
  - sets the accumulator register A (DATA_WIDTH+1 bits) to 0;
  - sets Q=multiplicador_in, q_minus_1=0 and the step counter to 0;
  - latches clear_pending=acc_clear_in.
- CALC, every edge:
  - {Q[0],q_minus_1} = 01: A+=M; = 10: A-=M; otherwise A is unchanged.
  - Then {A,Q,q_minus_1} shifts arithmetic right by 1.
  - The counter increments. After the DATA_WIDTH-th step the FSM goes to ACCUM.
- ACCUM, one edge:
  - P = {A[DATA_WIDTH-1:0],Q} is written to producto_out.
  - acc_next = clear_pending ? sext(P) : resultado_out + sext(P).
  - resultado_out ← acc_next, after overflow handling (see Configuration).
  - valid_out=1 for the next cycle; FSM returns to IDLE.
- Overflow: both addends share a sign and the sum's sign differs. This sets ovf_out. A load (clear_pending) never overflows.
- IDLE with acc_clear_in=1 and start_in=0: resultado_out←0 and ovf_out←0 on the next edge. No valid_out pulse.
- start_in and acc_clear_in while busy are ignored; operands are not re-sampled.
- The operand value -2^(N-1) is legal. A has one guard bit, so (-2^(N-1))² = 2^(2N-2) is exact.

## Timing
- Reset (asynchronous assert, synchronous release) values:
  - FSM state IDLE, so ready_out=1 and busy_out=0.
  - valid_out=0, producto_out=0, resultado_out=0, ovf_out=0.
  - Counter and A/Q/M registers are 0.
- Latency: start accepted on edge k → valid_out high in the cycle after edge k+DATA_WIDTH+1. That is DATA_WIDTH+1 clocks.
- Throughput: one operation per DATA_WIDTH+2 clocks.
  - ready_out returns to 1 in the same cycle valid_out is high.
  - A start_in in that cycle is accepted, so back-to-back issue is possible.
- Reset mid-operation: the operation is aborted and no valid_out pulse is produced. All outputs take their reset values.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- BOOTH_MAC_SAT_EN defined:
  - On overflow, resultado_out saturates: 2^(ACC_WIDTH-1)-1 on positive overflow, -2^(ACC_WIDTH-1) on negative overflow.
  - ovf_out is set.
- BOOTH_MAC_SAT_EN undefined:
  - resultado_out wraps modulo 2^ACC_WIDTH.
  - ovf_out is still set.

## Test plan
- Basic multiply (N=8, ACC=20): after reset, start 5 × -3 with clear → valid_out in the 9th cycle after acceptance; producto_out=-15, resultado_out=-15, ovf_out=0.
- Corner case: start -128 × -128 with clear → producto_out=16384. Then start 127 × -128 without clear → producto_out=-16256, resultado_out=128.
- Back-to-back accumulate: 7 × 6 with clear, then 10 × -2 issued in the valid cycle without clear → resultado_out 42, then 22 after another 10 clocks. No idle cycle between operations.
- Busy protection and standalone clear:
  - start_in pulses with new operands at cycles 2..8 of an operation are ignored; the original product results.
  - acc_clear_in alone in IDLE → resultado_out=0, ovf_out=0, no valid_out.
- Overflow (N=8, ACC=16): 127 × 127 with clear, then twice more without clear.
  - Third result without BOOTH_MAC_SAT_EN: resultado_out=-17149 (48387 wraps modulo 2^16), ovf_out=1.
  - Third result with BOOTH_MAC_SAT_EN: resultado_out=32767, ovf_out=1.
- Reset mid-operation: assert rst_n_in low during cycle 4 of CALC → all outputs go to reset values immediately and ready_out=1. No valid_out pulse occurs afterward.
